cache_opr_tracker: RTL and testbench
====================================

// Module: cache_opr_tracker
// PURPOSE
//  Completion side of the cache operation sequencer. Receives the 8 staged start strobes (opr_N_pulse)
//  and the per-operation done strobes from the operation modules, tracks outstanding ops, and returns
//  the single-cycle opr_finished that clears the sequencer counter. A watchdog guarantees opr_finished
//  even when an operation module never answers.
// PARAMETERS
//  NUM_OPR        8    number of staged operations (start/done vector width)
//  TIMEOUT_CYCLES 64   idle cycles in ACTIVE (no start/done event) before forced finish
//  TO_W           7    watchdog counter width, >= clog2(TIMEOUT_CYCLES+1)
//  CYC_W          16   width of trace_cycles statistic
// PORTS
//  clk           in   1        system clock
//  rst           in   1        synchronous reset, active-high
//  opr_start     in   NUM_OPR  bit i = opr_(i+1)_pulse from sequencer, 1-cycle strobes
//  opr_done      in   NUM_OPR  bit i = 1-cycle completion strobe from operation i+1
//  opr_finished  out  1        1-cycle pulse: trace complete (or timed out)
//  busy          out  1        1 while state != IDLE
//  started_mask  out  NUM_OPR  ops started in current trace
//  done_mask     out  NUM_OPR  ops completed in current trace
//  ops_done_cnt  out  4        popcount of done_mask, registered
//  timeout_err   out  1        sticky: last trace ended by watchdog
//  proto_err     out  1        sticky: protocol violation seen in current/last trace
//  trace_cycles  out  CYC_W    cycles ACTIVE->FINISH of last trace (see CONFIGURATION)
// BEHAVIOUR
//  - All state registered on posedge clk; rst=1 -> state IDLE, every output and mask 0, watchdog 0.
//    rst mid-trace abandons trace, no opr_finished generated.
//  - FSM IDLE/ACTIVE/FINISH. IDLE: any opr_start bit -> ACTIVE; masks and both err flags cleared, then
//    that cycle's start/done bits recorded. opr_done in IDLE ignored, sets proto_err.
//  - ACTIVE: started_mask |= opr_start; done_mask |= (opr_done & (started_mask|opr_start)).
//    Start and done of same bit in same cycle both recorded (zero-latency op).
//  - proto_err set (trace still proceeds) on: start of already-started bit (ignored); done of
//    unstarted bit (ignored, mask unchanged); done of already-done bit; start of bit i>0 while
//    bit i-1 not yet started (recorded anyway).
//  - ACTIVE -> FINISH when next-cycle masks are both all-ones; opr_finished = (state==FINISH), i.e.
//    high exactly one cycle, the cycle after the final done is sampled.
//  - Watchdog: cleared on entry to ACTIVE and on any accepted start/done; increments otherwise;
//    reaching TIMEOUT_CYCLES -> FINISH with timeout_err set. Saturates, never wraps.
//  - FINISH (1 cycle) -> IDLE; if opr_start nonzero in FINISH, go directly to ACTIVE as new trace
//    (masks/errs cleared, bits recorded). opr_done in FINISH ignored, no error.
//  - Masks and err flags hold their values in IDLE until next trace starts (readable post-trace).
//  - ops_done_cnt updates one cycle after done_mask; range 0..NUM_OPR.
// CONFIGURATION
//  - OPR_TRACK_STATS_EN defined: cycle counter cleared on IDLE->ACTIVE, increments each ACTIVE cycle,
//    saturates at 2^CYC_W-1; value latched into trace_cycles on entry to FINISH; reset -> 0.
//  - Not defined: counter not built; trace_cycles port kept, tied to 0.
// TESTING
//  1 Reset: hold rst 3 cycles with random start/done -> all outputs 0, busy 0.
//  2 Nominal: start bit i at cycle 4(i+1), done bit i 2 cycles later -> opr_finished one cycle
//    after done[7] (cycle 35), masks 8'hFF, ops_done_cnt 8, errs 0, trace_cycles 31 (STATS_EN).
//  3 Unstarted done: start bit0, pulse done[3] -> proto_err 1, done_mask 8'h00, trace continues.
//  4 Timeout: start bit0 only, no further events -> opr_finished after 64 idle cycles,
//    timeout_err 1, started_mask 8'h01; new start clears timeout_err.
//  5 Same-cycle: run nominal but assert start[7] and done[7] together -> finished next cycle,
//    proto_err 0; back-to-back start[0] during FINISH -> busy stays 1, masks 8'h01.
//  6 rst at cycle 20 of nominal trace -> no opr_finished, masks 0; fresh trace completes normally.

Source files
------------

// File: rtl/cache_opr_tracker.sv
// cache_opr_tracker
//   Completion side of the cache operation sequencer. It records which staged
//   operations have started and finished in the current trace, and then returns
//   a single-cycle opr_finished that clears the sequencer counter. A watchdog
//   forces opr_finished if an operation module stops answering.
//
//   Optional feature: define OPR_TRACK_STATS_EN to build the trace-length
//   counter. When the macro is not defined, trace_cycles is tied to 0.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   opr_start     per-op 1-cycle start strobes (bit i = opr_(i+1)_pulse)
//   opr_done      per-op 1-cycle completion strobes
//   opr_finished  1-cycle pulse while in FINISH (trace complete or timed out)
//   busy          state != IDLE
//   started_mask  ops started in current/last trace
//   done_mask     ops completed in current/last trace
//   ops_done_cnt  registered popcount of done_mask (lags it by one cycle)
//   timeout_err   sticky: last trace ended by the watchdog
//   proto_err     sticky: protocol violation in current/last trace
//   trace_cycles  cycles from the first start strobe to FINISH of the last trace
module cache_opr_tracker #(
  parameter int NUM_OPR        = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7,
  parameter int CYC_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_OPR-1:0] opr_start,
  input  logic [NUM_OPR-1:0] opr_done,
  output logic               opr_finished,
  output logic               busy,
  output logic [NUM_OPR-1:0] started_mask,
  output logic [NUM_OPR-1:0] done_mask,
  output logic [3:0]         ops_done_cnt,
  output logic               timeout_err,
  output logic               proto_err,
  output logic [CYC_W-1:0]   trace_cycles
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

  state_t             state_q, state_d;
  logic [NUM_OPR-1:0] started_q, started_d, done_q, done_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               tmo_q, tmo_d, perr_q, perr_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic               load_trace;

  // A new trace starts from empty masks, so the same update logic serves both
  // the ACTIVE case and the trace-start case (IDLE/FINISH with a start).
  logic [NUM_OPR-1:0] base_s, base_d, st_all, acc_done, new_start;
  logic               ev_err;

  assign base_s    = (state_q == ACTIVE) ? started_q : '0;
  assign base_d    = (state_q == ACTIVE) ? done_q    : '0;
  assign st_all    = base_s | opr_start;
  assign new_start = opr_start & ~base_s;
  // A done is accepted only for a started op that has not yet completed.
  assign acc_done  = opr_done & st_all & ~base_d;
  // Violations: restart, done of an unstarted op, repeated done, and out-of-order
  // start. A predecessor that starts in the same cycle counts as started.
  assign ev_err = (|(opr_start & base_s)) || (|(opr_done & ~st_all)) ||
                  (|(opr_done & base_d)) ||
                  (|(opr_start[NUM_OPR-1:1] & ~st_all[NUM_OPR-2:0]));

  function automatic logic [3:0] popcnt(input logic [NUM_OPR-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_OPR; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    started_d  = started_q;
    done_d     = done_q;
    tmo_d      = tmo_q;
    perr_d     = perr_q;
    wd_d       = '0;
    load_trace = 1'b0;
    cnt_d      = popcnt(done_q);
    case (state_q)
      IDLE: begin
        if (|opr_start) begin
          state_d    = ACTIVE;
          load_trace = 1'b1;
        end else if (|opr_done) begin
          perr_d = 1'b1;
        end
      end
      ACTIVE: begin
        started_d = st_all;
        done_d    = base_d | acc_done;
        perr_d    = perr_q | ev_err;
        if ((|new_start) || (|acc_done)) wd_d = '0;
        else if (wd_q == '1)             wd_d = wd_q;
        else                             wd_d = wd_q + TO_W'(1);
        // Completion has priority over a timeout landing in the same cycle.
        if ((&started_d) && (&done_d)) begin
          state_d = FINISH;
        end else if (wd_d >= TO_W'(TIMEOUT_CYCLES)) begin
          state_d = FINISH;
          tmo_d   = 1'b1;
        end
      end
      FINISH: begin
        // Dones here are stragglers of the closed trace and are dropped silently.
        if (|opr_start) begin
          state_d    = ACTIVE;
          load_trace = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_trace) begin
      started_d = opr_start;
      done_d    = acc_done;
      perr_d    = ev_err;
      tmo_d     = 1'b0;
      wd_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      started_q <= '0;
      done_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      perr_q    <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      perr_q    <= perr_d;
      wd_q      <= wd_d;
    end
  end

  assign opr_finished = (state_q == FINISH);
  assign busy         = (state_q != IDLE);
  assign started_mask = started_q;
  assign done_mask    = done_q;
  assign ops_done_cnt = cnt_q;
  assign timeout_err  = tmo_q;
  assign proto_err    = perr_q;

`ifdef OPR_TRACK_STATS_EN
  logic [CYC_W-1:0] cyc_q, cyc_d, tcyc_q, tcyc_d;

  // The start-strobe cycle is counted, so the counter loads 1 on trace start.
  // The latched value is then the distance from the start strobe to FINISH.
  always_comb begin
    cyc_d  = cyc_q;
    tcyc_d = tcyc_q;
    if (load_trace)                               cyc_d = CYC_W'(1);
    else if (state_q == ACTIVE && cyc_q != '1)    cyc_d = cyc_q + CYC_W'(1);
    if (state_q == ACTIVE && state_d == FINISH)   tcyc_d = cyc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      tcyc_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      tcyc_q <= tcyc_d;
    end
  end

  assign trace_cycles = tcyc_q;
`else
  assign trace_cycles = '0;
`endif

endmodule

// File: tb/tb_cache_opr_tracker.sv
// Directed bench for cache_opr_tracker: reset, nominal trace, protocol errors,
// watchdog timeout, same-cycle start/done with back-to-back trace, mid-trace reset.
module tb_cache_opr_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  opr_start = '0;
  logic [7:0]  opr_done  = '0;
  logic        opr_finished, busy, timeout_err, proto_err;
  logic [7:0]  started_mask, done_mask;
  logic [3:0]  ops_done_cnt;
  logic [15:0] trace_cycles;

  int n_cmp = 0;
  int n_err = 0;

`ifdef OPR_TRACK_STATS_EN
  localparam int NOM_CYC = 31;
  localparam int TMO_CYC = 65;
`else
  localparam int NOM_CYC = 0;
  localparam int TMO_CYC = 0;
`endif

  cache_opr_tracker dut (
    .clk(clk), .rst(rst), .opr_start(opr_start), .opr_done(opr_done),
    .opr_finished(opr_finished), .busy(busy), .started_mask(started_mask),
    .done_mask(done_mask), .ops_done_cnt(ops_done_cnt), .timeout_err(timeout_err),
    .proto_err(proto_err), .trace_cycles(trace_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; return #1 after the sampling edge.
  task automatic cyc(input logic [7:0] s, input logic [7:0] d);
    opr_start = s; opr_done = d;
    @(posedge clk); #1;
    opr_start = '0; opr_done = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Nominal schedule: start bit i at cycle 4(i+1), done 2 cycles later.
  // same7: done[7] together with start[7]; b2b: start[0] at cycle 33.
  task automatic trace(input bit same7, input bit b2b, input int rst_at, input int last,
                       output int fin_cyc, output int fin_cnt);
    logic [7:0] s, d;
    fin_cyc = -1; fin_cnt = 0;
    for (int c = 0; c <= last; c++) begin
      s = '0; d = '0;
      for (int i = 0; i < 8; i++) begin
        if (c == 4*(i+1)) s[i] = 1'b1;
        if (c == 4*(i+1)+2 && !(same7 && i == 7)) d[i] = 1'b1;
      end
      if (same7 && c == 32) d[7] = 1'b1;
      if (b2b && c == 33)   s[0] = 1'b1;
      rst = (c == rst_at);
      cyc(s, d);
      rst = 1'b0;
      if (opr_finished) begin fin_cnt++; fin_cyc = c + 1; end
    end
  endtask

  initial begin
    int fc, fn, k;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int fc, fn, tfin;
    // 1 reset with random inputs
    for (int i = 0; i < 3; i++) begin
      opr_start = 8'($urandom); opr_done = 8'($urandom); rst = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_busy", busy, 0);
    chk("rst_fin", opr_finished, 0);
    chk("rst_masks", {started_mask, done_mask}, 0);
    chk("rst_misc", {ops_done_cnt, timeout_err, proto_err, trace_cycles}, 0);
    rst = 1'b0; opr_start = '0; opr_done = '0;

    // 2 nominal
    trace(0, 0, -1, 40, fc, fn);
    chk("nom_fin_cyc", fc, 35);
    chk("nom_fin_cnt", fn, 1);
    chk("nom_started", started_mask, 8'hFF);
    chk("nom_done", done_mask, 8'hFF);
    chk("nom_cnt", ops_done_cnt, 8);
    chk("nom_errs", {timeout_err, proto_err}, 0);
    chk("nom_busy", busy, 0);
    chk("nom_tcyc", trace_cycles, NOM_CYC);

    // done in IDLE -> proto_err
    do_reset();
    cyc(8'h00, 8'h01);
    chk("idle_done_perr", proto_err, 1);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_mask", done_mask, 0);

    // out-of-order start
    do_reset();
    cyc(8'h02, 8'h00);
    chk("order_perr", proto_err, 1);
    chk("order_started", started_mask, 8'h02);

    // 3 unstarted done
    do_reset();
    cyc(8'h01, 8'h00);
    chk("ud_start_perr", proto_err, 0);
    cyc(8'h00, 8'h08);
    chk("ud_perr", proto_err, 1);
    chk("ud_done", done_mask, 8'h00);
    chk("ud_busy", busy, 1);
    chk("ud_started", started_mask, 8'h01);
    cyc(8'h00, 8'h01);
    chk("ud_done0", done_mask, 8'h01);
    chk("ud_cnt_lag", ops_done_cnt, 0);
    chk("ud_perr_sticky", proto_err, 1);
    cyc(8'h00, 8'h00);
    chk("ud_cnt", ops_done_cnt, 1);

    // 4 timeout
    do_reset();
    cyc(8'h01, 8'h00);
    tfin = -1;
    for (int c = 1; c < 200; c++) begin
      cyc(8'h00, 8'h00);
      if (opr_finished) begin tfin = c + 1; break; end
    end
    chk("tmo_fin_cyc", tfin, 65);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_started", started_mask, 8'h01);
    chk("tmo_perr", proto_err, 0);
    cyc(8'h00, 8'h00);
    chk("tmo_idle", busy, 0);
    chk("tmo_sticky", timeout_err, 1);
    chk("tmo_tcyc", trace_cycles, TMO_CYC);
    cyc(8'h01, 8'h00);
    chk("tmo_clear", timeout_err, 0);

    // 5 same-cycle start/done of bit 7, back-to-back start in FINISH
    do_reset();
    trace(1, 1, -1, 33, fc, fn);
    chk("same_fin_cyc", fc, 33);
    chk("same_fin_cnt", fn, 1);
    chk("b2b_busy", busy, 1);
    chk("b2b_started", started_mask, 8'h01);
    chk("b2b_done", done_mask, 8'h00);
    chk("b2b_perr", proto_err, 0);

    // 6 reset at cycle 20, then fresh trace
    do_reset();
    trace(0, 0, 20, 20, fc, fn);
    chk("mrst_fin", fn, 0);
    chk("mrst_masks", {started_mask, done_mask}, 0);
    chk("mrst_busy", busy, 0);
    trace(0, 0, -1, 40, fc, fn);
    chk("fresh_fin_cyc", fc, 35);
    chk("fresh_masks", {started_mask, done_mask}, 16'hFFFF);
    chk("fresh_errs", {timeout_err, proto_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
